// File: rtl/neural_pkg.sv
// Shared widths, FSM state type and saturation helper for the streaming dot-product neuron.
package neural_pkg;

  localparam int unsigned WGT_W = 19;
  localparam int unsigned PIX_W = 10;
  localparam int unsigned ACC_W = 40;
  localparam int unsigned OUT_W = 26;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_e;

  // Clamp a signed value into the range of a w-bit signed result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/neural_lane_tree.sv
// Per-lane signed multipliers (pixel zero-extended) followed by a registered adder tree.
module neural_lane_tree #(
  parameter int unsigned LANES = 2,
  parameter int unsigned WGT_W = 19,
  parameter int unsigned PIX_W = 10,
  parameter int unsigned SUM_W = WGT_W + PIX_W + 1 + $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANES*WGT_W-1:0]    wgt_i,
  input  logic [LANES*PIX_W-1:0]    pix_i,
  output logic signed [SUM_W-1:0]   sum_o
);

  localparam int unsigned PROD_W = WGT_W + PIX_W + 1;

  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  sum_q;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod_d[k] = PROD_W'($signed(wgt_i[k*WGT_W +: WGT_W]))
                * PROD_W'($signed({1'b0, pix_i[k*PIX_W +: PIX_W]}));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_d = sum_d + SUM_W'(prod_q[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
      sum_q <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) prod_q[k] <= prod_d[k];
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/neural_dot_stream.sv
// Streaming signed dot product with framing check and saturated, rescaled result.
// Define NEURAL_RELU_EN to clamp negative results to zero after saturation.
module neural_dot_stream #(
  parameter int unsigned WGT_W      = neural_pkg::WGT_W,
  parameter int unsigned PIX_W      = neural_pkg::PIX_W,
  parameter int unsigned LANES      = 2,
  parameter int unsigned N_INPUTS   = 784,
  parameter int unsigned ACC_W      = neural_pkg::ACC_W,
  parameter int unsigned FRAC_SHIFT = 0,
  parameter int unsigned OUT_W      = neural_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WGT_W-1:0]   in_wgt,
  input  logic [LANES*PIX_W-1:0]   in_pix,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_result,
  output logic                     out_err
);

  import neural_pkg::*;

  localparam int unsigned SUM_W = WGT_W + PIX_W + 1 + $clog2(LANES);
  localparam int unsigned BEATS = N_INPUTS / LANES;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     err_q, err_d;
  logic signed [OUT_W-1:0]  res_q, res_d;

  logic                     p_vld_q, p_first_q, p_last_q;
  logic                     s_vld_q, s_first_q, s_last_q;
  logic                     a_last_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [SUM_W-1:0]  sum;

  logic                     accept_c, cnt_full_c, close_c;
  logic signed [ACC_W-1:0]  shifted_c;
  logic signed [63:0]       sat_c, act_c;

  neural_lane_tree #(
    .LANES (LANES),
    .WGT_W (WGT_W),
    .PIX_W (PIX_W),
    .SUM_W (SUM_W)
  ) u_tree (
    .clk   (clk),
    .rst_n (rst),
    .wgt_i (in_wgt),
    .pix_i (in_pix),
    .sum_o (sum)
  );

  assign accept_c   = in_valid & in_ready_q;
  assign cnt_full_c = (cnt_q == CNT_W'(BEATS - 1));
  // A vector closes on in_last or when the expected beat count is reached.
  assign close_c    = in_last | cnt_full_c;

  assign shifted_c = acc_q >>> FRAC_SHIFT;
  assign sat_c     = saturate(64'(shifted_c), OUT_W);
`ifdef NEURAL_RELU_EN
  assign act_c     = sat_c[63] ? 64'sd0 : sat_c;
`else
  assign act_c     = sat_c;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    res_d       = res_q;
    case (state_q)
      IDLE, ACCUM: begin
        in_ready_d = 1'b1;
        if (accept_c) begin
          state_d = ACCUM;
          cnt_d   = cnt_q + CNT_W'(1);
          if (in_last != cnt_full_c) err_d = 1'b1;
          if (close_c) begin
            state_d    = DRAIN;
            cnt_d      = '0;
            in_ready_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (a_last_q) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          res_d       = OUT_W'(act_c);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      res_q       <= res_d;
    end
  end

  // Beat markers travel alongside the product/sum stages; first beat reloads the accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_vld_q   <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
      s_vld_q   <= 1'b0;
      s_first_q <= 1'b0;
      s_last_q  <= 1'b0;
      a_last_q  <= 1'b0;
      acc_q     <= '0;
    end else begin
      p_vld_q   <= accept_c;
      p_first_q <= accept_c & (state_q == IDLE);
      p_last_q  <= accept_c & close_c;
      s_vld_q   <= p_vld_q;
      s_first_q <= p_first_q;
      s_last_q  <= p_last_q;
      a_last_q  <= s_last_q;
      if (s_vld_q) acc_q <= s_first_q ? ACC_W'(sum) : acc_q + ACC_W'(sum);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_neural_dot_stream.sv
// Directed and randomized bench: small 2-lane/4-term instance and a 4-lane/784-term instance.
module tb_neural_dot_stream;

  localparam int WGT_W = 19;
  localparam int PIX_W = 10;
  localparam int OUT_W = 26;
  localparam int NB    = 784;
  localparam int BB    = NB / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                    a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_err;
  logic [2*WGT_W-1:0]      a_in_wgt;
  logic [2*PIX_W-1:0]      a_in_pix;
  logic signed [OUT_W-1:0] a_out_result;

  logic                    b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_err;
  logic [4*WGT_W-1:0]      b_in_wgt;
  logic [4*PIX_W-1:0]      b_in_pix;
  logic signed [OUT_W-1:0] b_out_result;

  int n_pass = 0;
  int n_total = 0;
  int bw [NB];
  int bp [NB];

  neural_dot_stream #(.LANES(2), .N_INPUTS(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_wgt(a_in_wgt), .in_pix(a_in_pix), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_result(a_out_result), .out_err(a_out_err)
  );

  neural_dot_stream #(.LANES(4), .N_INPUTS(NB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_wgt(b_in_wgt), .in_pix(b_in_pix), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_result(b_out_result), .out_err(b_out_err)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint act(input longint v);
`ifdef NEURAL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: plain dot product, 40-bit wrap, clamp to OUT_W signed, optional ReLU.
  function automatic longint b_model();
    longint acc = 0;
    longint lim = longint'(1) <<< (OUT_W - 1);
    for (int i = 0; i < NB; i++) acc += longint'(bw[i]) * longint'(bp[i]);
    acc = (acc <<< 24) >>> 24;
    if (acc > lim - 1) acc = lim - 1;
    if (acc < -lim) acc = -lim;
    return act(acc);
  endfunction

  task automatic a_beat(input int w0, input int w1, input int p0, input int p1, input bit last);
    int n = 0;
    @(negedge clk);
    a_in_wgt   = {WGT_W'(w1), WGT_W'(w0)};
    a_in_pix   = {PIX_W'(p1), PIX_W'(p0)};
    a_in_last  = last;
    a_in_valid = 1'b1;
    while (a_in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("a_ready_timeout", a_in_ready, 1);
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    a_in_last = 1'b0;
  endtask

  task automatic a_get(input string tag, input longint exp, input bit exp_err);
    int n = 0;
    while (a_out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_valid"}, a_out_valid, 1);
    check({tag, "_result"}, a_out_result, exp);
    check({tag, "_err"}, a_out_err, 64'(exp_err));
    @(negedge clk);
    a_out_ready = 1'b1;
    @(posedge clk);
    #1 a_out_ready = 1'b0;
    check({tag, "_released"}, a_out_valid, 0);
  endtask

  task automatic b_vec(input bit gaps);
    for (int j = 0; j < BB; j++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (gaps && $urandom_range(0, 1) == 0) begin b_in_valid = 1'b0; @(negedge clk); end
      for (int k = 0; k < 4; k++) begin
        b_in_wgt[k*WGT_W +: WGT_W] = WGT_W'(bw[j*4+k]);
        b_in_pix[k*PIX_W +: PIX_W] = PIX_W'(bp[j*4+k]);
      end
      b_in_last  = (j == BB - 1);
      b_in_valid = 1'b1;
      while (b_in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) check("b_ready_timeout", b_in_ready, 1);
      @(posedge clk);
      #1 b_in_valid = 1'b0;
      b_in_last = 1'b0;
    end
  endtask

  task automatic b_get(input string tag, input longint exp);
    int n = 0;
    while (b_out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check({tag, "_valid"}, b_out_valid, 1);
    check({tag, "_result"}, b_out_result, exp);
    check({tag, "_err"}, b_out_err, 0);
    @(negedge clk);
    b_out_ready = 1'b1;
    @(posedge clk);
    #1 b_out_ready = 1'b0;
  endtask

  initial begin
    int bad;
    rst = 1'b0;
    a_in_valid = 0; a_in_last = 0; a_in_wgt = '0; a_in_pix = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_last = 0; b_in_wgt = '0; b_in_pix = '0; b_out_ready = 0;
    #2;
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_result", a_out_result, 0);
    check("rst_out_err", a_out_err, 0);
    @(negedge clk) rst = 1'b1;

    // Basic vector with latency check: result rises 3 edges after the last-beat accept.
    a_beat(3, -2, 10, 4, 0);
    a_beat(5, 1, 2, 7, 1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1 check($sformatf("lat_edge%0d", i), a_out_valid, (i == 3) ? 1 : 0);
    end
    a_get("basic", act(39), 0);

    // Backpressure: result held, input refused even with in_valid asserted.
    a_beat(3, -2, 10, 4, 0);
    a_beat(5, 1, 2, 7, 1);
    repeat (4) @(posedge clk);
    #1;
    bad = 0;
    a_in_valid = 1'b1; a_in_wgt = '1; a_in_pix = '1; a_in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (a_out_result !== OUT_W'(act(39)) || a_in_ready !== 1'b0 || a_out_valid !== 1'b1) bad++;
    end
    a_in_valid = 1'b0; a_in_last = 1'b0;
    check("hold_stable", bad, 0);
    a_get("hold", act(39), 0);

    // Missing in_last: closes at the expected count and flags a framing error.
    a_beat(3, -2, 10, 4, 0);
    a_beat(5, 1, 2, 7, 0);
    a_get("nolast", act(39), 1);

    // Reset mid-vector clears everything immediately; partial sum must not leak.
    a_beat(100, 100, 1000, 1000, 0);
    @(negedge clk) rst = 1'b0;
    #1;
    check("mid_rst_in_ready", a_in_ready, 0);
    check("mid_rst_out_valid", a_out_valid, 0);
    check("mid_rst_out_result", a_out_result, 0);
    check("mid_rst_out_err", a_out_err, 0);
    @(negedge clk) rst = 1'b1;
    a_beat(-4, 6, 1000, 3, 0);
    a_beat(2, -1, 0, 1023, 1);
    a_get("post_rst", act(-5005), 0);

    // Early in_last: vector closes on beat 1, error sticks through a clean vector.
    a_beat(7, -3, 100, 50, 1);
    a_get("early", act(550), 1);
    a_beat(3, -2, 10, 4, 0);
    a_beat(5, 1, 2, 7, 1);
    a_get("after_err", act(39), 1);

    // Full-scale negative vector saturates to the most negative result.
    for (int i = 0; i < NB; i++) begin bw[i] = -(1 << 18); bp[i] = 1023; end
    b_vec(0);
    b_get("sat_neg", act(-(longint'(1) <<< (OUT_W - 1))));

    // Randomized vectors with gapped valid against the reference model.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < NB; i++) begin
        bw[i] = (v == 3) ? int'($urandom_range(0, (1 << 19) - 1)) - (1 << 18)
                         : int'($urandom_range(0, 2047)) - 1024;
        bp[i] = int'($urandom_range(0, 1023));
      end
      b_vec(v != 1);
      b_get($sformatf("rand%0d", v), b_model());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
